// File: rtl/gemm_pkg.sv
// Shared types and constants for the GeMM result readback path.
package gemm_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StDrain = 2'd2,
      StDone  = 2'd3
   } streamer_state_e;

   localparam int StreamerFifoDepth = 2;

endpackage

// File: rtl/gemm_stream_fifo.sv
// Two-entry synchronous FIFO; push and pop in the same cycle are legal even when full.
module gemm_stream_fifo
   import gemm_pkg::*;
#(
   parameter int Width = 34
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [1:0]       count
);

   logic [Width-1:0] mem [StreamerFifoDepth];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       cnt_q;

   // Storage has no reset; the occupancy count decides what is visible.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt_q  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign count = cnt_q;
   assign empty = (cnt_q == 2'd0);
   assign full  = (cnt_q == 2'(StreamerFifoDepth));

endmodule

// File: rtl/gemm_result_streamer.sv
// Reads matrix C out of the C SRAM in row-major order and streams it on valid/ready.
module gemm_result_streamer
   import gemm_pkg::*;
#(
   parameter int AddrWidth      = 16,
   parameter int DataWidthC     = 32,
   parameter int SRAMAddrWidthC = AddrWidth - $clog2(DataWidthC/8),
   parameter int FifoDepth      = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   input  logic [AddrWidth-1:0]      M_size_i,
   input  logic [AddrWidth-1:0]      N_size_i,
   output logic [SRAMAddrWidthC-1:0] sram_c_addr_o,
   output logic                      sram_c_re_o,
   input  logic [DataWidthC-1:0]     sram_c_rdata_i,
   output logic [DataWidthC-1:0]     data_o,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic                      row_last_o,
   output logic                      last_o,
   output logic                      busy_o,
   output logic                      done_o
);

   localparam int FifoWidth = DataWidthC + 2;

   streamer_state_e      state_q, state_d;
   logic [AddrWidth-1:0] n_size_q, total_q, idx_q, n_cnt_q;
   logic                 inflight_q, tag_row_last_q, tag_last_q;
   logic                 issue, pop, n_is_last, idx_is_last;
   logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [1:0]           fifo_count;
   logic [2:0]           occ;
   logic [FifoWidth-1:0] fifo_rdata, ret_beat;

   // Occupancy after this cycle's pop: queued entries plus the read returning now.
   assign pop         = valid_o & ready_i;
   assign occ         = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign n_is_last   = (n_cnt_q == n_size_q - AddrWidth'(1));
   assign idx_is_last = (idx_q == total_q - AddrWidth'(1));
   assign issue       = (state_q == StIssue) && (occ < 3'(FifoDepth));

   assign sram_c_re_o   = issue;
   assign sram_c_addr_o = issue ? idx_q[SRAMAddrWidthC-1:0] : '0;
   assign busy_o        = (state_q == StIssue) || (state_q == StDrain);
   assign done_o        = (state_q == StDone);

   // Returning read data bypasses the FIFO when it is empty and the consumer is ready.
   assign ret_beat  = {tag_row_last_q, tag_last_q, sram_c_rdata_i};
   assign valid_o   = ~fifo_empty | inflight_q;
   assign fifo_push = inflight_q & ~(fifo_empty & ready_i);
   assign fifo_pop  = ~fifo_empty & ready_i;

   // Output beat: FIFO head first, else the read landing this cycle, else zero.
   always_comb begin
      {row_last_o, last_o, data_o} = '0;
      if (!fifo_empty)     {row_last_o, last_o, data_o} = fifo_rdata;
      else if (inflight_q) {row_last_o, last_o, data_o} = ret_beat;
   end

   // Next-state logic; DRAIN looks at post-pop occupancy so done follows the last beat directly.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start_i) state_d = (M_size_i == '0 || N_size_i == '0) ? StDone : StIssue;
         StIssue: if (issue && idx_is_last) state_d = StDrain;
         StDrain: if (occ == 3'd0) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State, size latches, linear index / column counter and in-flight tags.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q        <= StIdle;
         n_size_q       <= '0;
         total_q        <= '0;
         idx_q          <= '0;
         n_cnt_q        <= '0;
         inflight_q     <= 1'b0;
         tag_row_last_q <= 1'b0;
         tag_last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue;
         if (state_q == StIdle && start_i) begin
            n_size_q <= N_size_i;
            total_q  <= M_size_i * N_size_i;
            idx_q    <= '0;
            n_cnt_q  <= '0;
         end
         if (issue) begin
            tag_row_last_q <= n_is_last;
            tag_last_q     <= idx_is_last;
            idx_q          <= idx_q + AddrWidth'(1);
            n_cnt_q        <= n_is_last ? '0 : n_cnt_q + AddrWidth'(1);
         end
      end
   end

   gemm_stream_fifo #(.Width(FifoWidth)) u_fifo (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .push  (fifo_push),
      .wdata (ret_beat),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // The issue rule must never let a push land on a full FIFO without a pop.
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_gemm_result_streamer.sv
// Directed bench for gemm_result_streamer with a 1-cycle-latency SRAM model.
module tb_gemm_result_streamer;

   localparam int AW  = 16;
   localparam int DW  = 32;
   localparam int SAW = AW - $clog2(DW/8);

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic           ready = 1'b0;
   logic [AW-1:0]  m_size = '0;
   logic [AW-1:0]  n_size = '0;
   logic [SAW-1:0] addr;
   logic           re;
   logic [DW-1:0]  rdata = '0;
   logic [DW-1:0]  data;
   logic           valid, row_last, last, busy, done;
   logic [DW-1:0]  sram_base = '0;
   int             checks = 0;
   int             failures = 0;

   always #5 clk = ~clk;

   gemm_result_streamer #(.AddrWidth(AW), .DataWidthC(DW)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .start_i       (start),
      .M_size_i      (m_size),
      .N_size_i      (n_size),
      .sram_c_addr_o (addr),
      .sram_c_re_o   (re),
      .sram_c_rdata_i(rdata),
      .data_o        (data),
      .valid_o       (valid),
      .ready_i       (ready),
      .row_last_o    (row_last),
      .last_o        (last),
      .busy_o        (busy),
      .done_o        (done)
   );

   // SRAM model: C[i] = sram_base + i, data one cycle after the read.
   always @(posedge clk) if (re) rdata <= sram_base + DW'(addr);

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_re"}, re, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_data"}, data, 0);
      chk({tag, "_addr"}, addr, 0);
      chk({tag, "_last"}, last, 0);
      chk({tag, "_row_last"}, row_last, 0);
   endtask

   // mode 0: always ready; 1: repeating 1,0,0,1,0,1,1 from first valid; 2: low until cycle 12
   function automatic logic rdy(input int mode, input int k);
      logic [6:0] pat;
      pat = 7'b1101001;
      case (mode)
         1:       return (k < 2) ? 1'b1 : pat[(k-2) % 7];
         2:       return (k >= 12);
         default: return 1'b1;
      endcase
   endfunction

   // One transfer; cycle 0 is the start_i cycle. Negative expectations are skipped.
   task automatic run_xfer(input int m, input int n, input int base, input int mode,
                           input int exp_first, input int exp_done, input int restart_k,
                           input int rst_beats);
      int            total = m * n;
      int            issued = 0, acc = 0, done_cnt = 0;
      int            done_k = -1, last_acc_k = -1, first_k = -1;
      logic          pv = 1'b0, pr = 1'b0;
      logic [DW+1:0] pbeat = '0;
      bit            fin = 1'b0;
      sram_base = DW'(base);
      @(negedge clk);
      start = 1'b1; m_size = AW'(m); n_size = AW'(n); ready = rdy(mode, 0);
      #1 chk("k0_re", re, 0);
      for (int k = 1; k < 300 && !fin; k++) begin
         @(negedge clk);
         start = (k == restart_k);
         if (k == restart_k) begin m_size = 9; n_size = 9; end
         if (rst_beats > 0 && acc == rst_beats) begin
            rst_n = 1'b0; ready = 1'b0;
            @(negedge clk);
            rst_n = 1'b1; start = 1'b0;
            #1 check_idle("post_rst");
            return;
         end
         ready = rdy(mode, k);
         #1;
         if (k == 1) chk("busy_k1", busy, total > 0);
         if (re) begin
            chk("addr", addr, issued);
            chk("re_cap", (issued - acc - int'(valid && ready)) < 2, 1);
            issued++;
         end
         if (valid) begin
            if (first_k < 0) begin
               first_k = k;
               if (exp_first >= 0) chk("first_valid", k, exp_first);
            end
            if (pv && !pr) chk("hold", {row_last, last, data}, pbeat);
            if (ready) begin
               chk("beat_data", data, base + acc);
               chk("beat_tags", {row_last, last}, {(acc % n) == n - 1, acc == total - 1});
               acc++;
               last_acc_k = k;
            end
         end
         pv = valid; pr = ready; pbeat = {row_last, last, data};
         if (done) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
         if (done_k >= 0 && k >= done_k + 2) fin = 1'b1;
      end
      start = 1'b0;
      if (!fin) chk("timeout", 0, 1);
      chk("beats", acc, total);
      chk("reads", issued, total);
      chk("done_once", done_cnt, 1);
      if (exp_done >= 0) chk("done_cyc", done_k, exp_done);
      if (total > 0) chk("done_after_last", done_k, last_acc_k + 1);
   endtask

   initial begin
      rst_n = 1'b0; ready = 1'b1;
      repeat (3) @(negedge clk);
      #1 check_idle("reset");
      @(negedge clk) rst_n = 1'b1;
      run_xfer(2, 3, 100, 0,  2,  8, -1, 0);
      run_xfer(2, 3, 200, 1, -1, -1, -1, 0);
      run_xfer(0, 5,   0, 0, -1,  1, -1, 0);
      run_xfer(4, 0,   0, 0, -1,  1, -1, 0);
      run_xfer(1, 1,  40, 2,  2, 13, -1, 0);
      run_xfer(3, 3,  60, 0,  2, -1,  4, 0);
      run_xfer(4, 4, 300, 0,  2, -1, -1, 4);
      run_xfer(4, 4, 500, 0,  2, 18, -1, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
